wt_mem_arbiter: RTL and testbench

WT_MEM_ARBITER -- requirements
Module: wt_mem_arbiter

---
 rtl/wt_cache_pkg.sv | 17 +
 rtl/wt_mem_arbiter_if.sv | 40 ++++
 rtl/wt_rr_arb.sv | 61 ++++++
 rtl/wt_mem_arbiter.sv | 175 +++++++++++++++++
 tb/tb_wt_mem_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wt_cache_pkg.sv
// rtl/wt_cache_pkg.sv - Shared widths, defaults and FSM encoding for the write-through memory arbiter.
package wt_cache_pkg;

  localparam int unsigned IdWidthDefault = 2;
  localparam int unsigned MaxTxDefault   = 4;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  // Port index field width; a single port still carries a 1-bit index.
  function automatic int unsigned port_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wt_mem_arbiter_if.sv
// rtl/wt_mem_arbiter_if.sv - Requester-side and memory-side signal bundle of the arbiter.
interface wt_mem_arbiter_if import wt_cache_pkg::*; #(
  parameter int unsigned NumPorts  = 2,
  parameter int unsigned IdWidth   = IdWidthDefault,
  parameter int unsigned ReqWidth  = 128,
  parameter int unsigned RtrnWidth = 192,
  parameter int unsigned PortIdxW  = port_idx_w(NumPorts)
);

  logic [NumPorts-1:0]                port_req_i;
  logic [NumPorts-1:0]                port_ack_o;
  logic [NumPorts-1:0][ReqWidth-1:0]  port_data_i;
  logic [NumPorts-1:0][IdWidth-1:0]   port_tid_i;
  logic [NumPorts-1:0]                port_rtrn_vld_o;
  logic [RtrnWidth-1:0]               port_rtrn_o;
  logic [IdWidth-1:0]                 port_rtrn_tid_o;

  logic                               mem_req_o;
  logic                               mem_ack_i;
  logic [ReqWidth-1:0]                mem_data_o;
  logic [PortIdxW+IdWidth-1:0]        mem_tid_o;
  logic                               mem_rtrn_vld_i;
  logic [RtrnWidth-1:0]               mem_rtrn_i;
  logic [PortIdxW+IdWidth-1:0]        mem_rtrn_tid_i;

  modport slave (
    input  port_req_i, port_data_i, port_tid_i,
    input  mem_ack_i, mem_rtrn_vld_i, mem_rtrn_i, mem_rtrn_tid_i,
    output port_ack_o, port_rtrn_vld_o, port_rtrn_o, port_rtrn_tid_o,
    output mem_req_o, mem_data_o, mem_tid_o
  );

  modport master (
    output port_req_i, port_data_i, port_tid_i,
    output mem_ack_i, mem_rtrn_vld_i, mem_rtrn_i, mem_rtrn_tid_i,
    input  port_ack_o, port_rtrn_vld_o, port_rtrn_o, port_rtrn_tid_o,
    input  mem_req_o, mem_data_o, mem_tid_o
  );

endinterface

// File: rtl/wt_rr_arb.sv
// rtl/wt_rr_arb.sv - Port arbiter: round-robin from last_grant+1, or lowest index first
// when WT_MEM_ARB_FIXED_PRIO_EN is defined.
module wt_rr_arb #(
  parameter int unsigned NumPorts = 2,
  parameter int unsigned IdxW     = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NumPorts-1:0] req,
  input  logic                upd_en,
  output logic [NumPorts-1:0] gnt,
  output logic [IdxW-1:0]     gnt_idx
);

`ifdef WT_MEM_ARB_FIXED_PRIO_EN
  logic unused_ok;
  assign unused_ok = ^{clk_i, rst_i, upd_en};

  // Walk downwards so the lowest requesting index is the one left standing.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    for (int i = int'(NumPorts) - 1; i >= 0; i--) begin
      if (req[i]) begin
        gnt     = '0;
        gnt[i]  = 1'b1;
        gnt_idx = IdxW'(i);
      end
    end
  end
`else
  logic [IdxW-1:0] last_grant;
  logic [IdxW-1:0] cand;
  logic            found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int i = 1; i <= int'(NumPorts); i++) begin
      cand = IdxW'((int'(last_grant) + i) % int'(NumPorts));
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // Reset to the top index so port 0 is searched first.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_grant <= IdxW'(NumPorts - 1);
    end else if (upd_en) begin
      last_grant <= gnt_idx;
    end
  end
`endif

endmodule

// File: rtl/wt_mem_arbiter.sv
// rtl/wt_mem_arbiter.sv - Arbitrates cache requester ports onto one memory channel and routes returns by ID.
// Define WT_MEM_ARB_FIXED_PRIO_EN to replace round-robin with fixed priority.
module wt_mem_arbiter import wt_cache_pkg::*; #(
  parameter int unsigned NumPorts  = 2,
  parameter int unsigned IdWidth   = IdWidthDefault,
  parameter int unsigned ReqWidth  = 128,
  parameter int unsigned RtrnWidth = 192,
  parameter int unsigned MaxTx     = MaxTxDefault
) (
  input logic             clk_i,
  input logic             rst_i,
  wt_mem_arbiter_if.slave bus
);

  localparam int unsigned PortIdxW = port_idx_w(NumPorts);
  localparam int unsigned CntW     = $clog2(MaxTx + 1);

  typedef logic [CntW-1:0] cnt_t;

  arb_state_e            state_q, state_d;
  logic [NumPorts-1:0]   eligible;
  logic [NumPorts-1:0]   gnt;
  logic [NumPorts-1:0]   inc;
  logic [NumPorts-1:0]   dec;
  logic [PortIdxW-1:0]   gnt_idx;
  logic [PortIdxW-1:0]   port_q;
  logic [ReqWidth-1:0]   data_q;
  logic [ReqWidth-1:0]   data_mux;
  logic [IdWidth-1:0]    tid_q;
  logic [IdWidth-1:0]    tid_mux;
  logic                  grant_en;
  logic                  busy;
  cnt_t                  outstanding [NumPorts];

  logic [PortIdxW-1:0]   rtrn_port_in;
  logic                  rtrn_idx_ok;
  logic                  rtrn_vld_q;
  logic [PortIdxW-1:0]   rtrn_port_q;
  logic [RtrnWidth-1:0]  rtrn_data_q;
  logic [IdWidth-1:0]    rtrn_tid_q;

  always_comb begin
    eligible = '0;
    for (int p = 0; p < int'(NumPorts); p++) begin
      eligible[p] = bus.port_req_i[p] && (outstanding[p] < cnt_t'(MaxTx));
    end
  end

  assign busy     = (state_q == ARB_BUSY);
  assign grant_en = (state_q == ARB_IDLE) && (|eligible);

  wt_rr_arb #(
    .NumPorts (NumPorts),
    .IdxW     (PortIdxW)
  ) u_arb (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req     (eligible),
    .upd_en  (grant_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_IDLE: if (|eligible)     state_d = ARB_BUSY;
      ARB_BUSY: if (bus.mem_ack_i) state_d = ARB_IDLE;
      default:                     state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    data_mux = '0;
    tid_mux  = '0;
    for (int p = 0; p < int'(NumPorts); p++) begin
      if (gnt[p]) begin
        data_mux = data_mux | bus.port_data_i[p];
        tid_mux  = tid_mux | bus.port_tid_i[p];
      end
    end
  end

  // The request is captured at grant time so the memory side sees a stable beat until acked.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ARB_IDLE;
      data_q  <= '0;
      tid_q   <= '0;
      port_q  <= '0;
    end else begin
      state_q <= state_d;
      if (grant_en) begin
        data_q <= data_mux;
        tid_q  <= tid_mux;
        port_q <= gnt_idx;
      end
    end
  end

  assign bus.mem_req_o  = busy;
  assign bus.mem_data_o = data_q;
  assign bus.mem_tid_o  = {port_q, tid_q};

  always_comb begin
    bus.port_ack_o = '0;
    for (int p = 0; p < int'(NumPorts); p++) begin
      bus.port_ack_o[p] = busy && bus.mem_ack_i && (port_q == PortIdxW'(p));
    end
  end

  assign inc = bus.port_ack_o;

  assign rtrn_port_in = bus.mem_rtrn_tid_i[PortIdxW+IdWidth-1 -: PortIdxW];
  assign rtrn_idx_ok  = int'(rtrn_port_in) < int'(NumPorts);

  always_comb begin
    dec = '0;
    for (int p = 0; p < int'(NumPorts); p++) begin
      dec[p] = bus.mem_rtrn_vld_i && rtrn_idx_ok && (rtrn_port_in == PortIdxW'(p));
    end
  end

  // Counters saturate at zero; an ack and a return in the same cycle cancel out.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int p = 0; p < int'(NumPorts); p++) begin
        outstanding[p] <= '0;
      end
    end else begin
      for (int p = 0; p < int'(NumPorts); p++) begin
        if (inc[p] && !dec[p]) begin
          outstanding[p] <= outstanding[p] + cnt_t'(1);
        end else if (dec[p] && !inc[p] && (outstanding[p] != '0)) begin
          outstanding[p] <= outstanding[p] - cnt_t'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rtrn_vld_q  <= 1'b0;
      rtrn_port_q <= '0;
      rtrn_data_q <= '0;
      rtrn_tid_q  <= '0;
    end else begin
      rtrn_vld_q <= bus.mem_rtrn_vld_i && rtrn_idx_ok;
      if (bus.mem_rtrn_vld_i && rtrn_idx_ok) begin
        rtrn_port_q <= rtrn_port_in;
        rtrn_data_q <= bus.mem_rtrn_i;
        rtrn_tid_q  <= bus.mem_rtrn_tid_i[IdWidth-1:0];
      end
    end
  end

  always_comb begin
    bus.port_rtrn_vld_o = '0;
    for (int p = 0; p < int'(NumPorts); p++) begin
      bus.port_rtrn_vld_o[p] = rtrn_vld_q && (rtrn_port_q == PortIdxW'(p));
    end
  end

  assign bus.port_rtrn_o     = rtrn_data_q;
  assign bus.port_rtrn_tid_o = rtrn_tid_q;

  for (genvar p = 0; p < NumPorts; p++) begin : g_chk
    a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
      !(dec[p] && (outstanding[p] == '0)));
  end

  a_rtrn_idx_valid: assert property (@(posedge clk_i) disable iff (rst_i)
    !(bus.mem_rtrn_vld_i && !rtrn_idx_ok));

endmodule

// File: tb/tb_wt_mem_arbiter.sv
// tb/tb_wt_mem_arbiter.sv - Directed self-checking bench for wt_mem_arbiter.
module tb_wt_mem_arbiter;
  import wt_cache_pkg::*;

  localparam int unsigned NP  = 2;
  localparam int unsigned IW  = 2;
  localparam int unsigned RQW = 128;
  localparam int unsigned RTW = 192;
  localparam int unsigned MT  = 4;
  localparam int unsigned PIW = port_idx_w(NP);
  localparam int unsigned TW  = PIW + IW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  wt_mem_arbiter_if #(
    .NumPorts(NP), .IdWidth(IW), .ReqWidth(RQW), .RtrnWidth(RTW), .PortIdxW(PIW)
  ) bus ();

  wt_mem_arbiter #(
    .NumPorts(NP), .IdWidth(IW), .ReqWidth(RQW), .RtrnWidth(RTW), .MaxTx(MT)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  function automatic logic [RQW-1:0] mk_data(input int p, input int n);
    return {32'hC0DE_0000 + 32'(p), 32'(n), 64'h0123_4567_89AB_CDEF};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.port_req_i     = '0;
    bus.port_data_i    = '0;
    bus.port_tid_i     = '0;
    bus.mem_ack_i      = 1'b0;
    bus.mem_rtrn_vld_i = 1'b0;
    bus.mem_rtrn_i     = '0;
    bus.mem_rtrn_tid_i = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.mem_req_o === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    bus.port_req_i = 2'b11;
    bus.mem_ack_i  = 1'b1;
    tick();
    tick();
    checks++; if (bus.mem_req_o !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %0h expected 0", bus.mem_req_o); end
    checks++; if (bus.port_ack_o !== 2'b00) begin errors++; $display("FAIL reset_port_ack: got %0h expected 0", bus.port_ack_o); end
    checks++; if (bus.port_rtrn_vld_o !== 2'b00) begin errors++; $display("FAIL reset_rtrn_vld: got %0h expected 0", bus.port_rtrn_vld_o); end
    checks++; if (bus.mem_data_o !== '0) begin errors++; $display("FAIL reset_mem_data: got %0h expected 0", bus.mem_data_o); end
    checks++; if (bus.mem_tid_o !== '0) begin errors++; $display("FAIL reset_mem_tid: got %0h expected 0", bus.mem_tid_o); end
    checks++; if (bus.port_rtrn_o !== '0) begin errors++; $display("FAIL reset_rtrn_data: got %0h expected 0", bus.port_rtrn_o); end
    checks++; if (dut.outstanding[0] !== 3'd0) begin errors++; $display("FAIL reset_outstanding: got %0d expected 0", dut.outstanding[0]); end
    clear_inputs();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_round_robin();
    bit ok;
    int exp_port;
    logic [TW-1:0] exp_tid;
    do_reset();
    bus.port_data_i[0] = mk_data(0, 0);
    bus.port_data_i[1] = mk_data(1, 0);
    bus.port_tid_i[0]  = 2'd1;
    bus.port_tid_i[1]  = 2'd2;
    bus.port_req_i     = 2'b11;
    for (int g = 0; g < 4; g++) begin
`ifdef WT_MEM_ARB_FIXED_PRIO_EN
      exp_port = 0;
`else
      exp_port = g % 2;
`endif
      exp_tid = (exp_port == 0) ? 3'b001 : 3'b110;
      wait_req(ok);
      checks++; if (!ok) begin errors++; $display("FAIL rr_req_timeout: grant %0d got no mem_req_o expected 1", g); break; end
      checks++; if (bus.mem_tid_o !== exp_tid) begin errors++; $display("FAIL rr_tid: grant %0d got %0h expected %0h", g, bus.mem_tid_o, exp_tid); end
      checks++; if (bus.mem_data_o !== mk_data(exp_port, 0)) begin errors++; $display("FAIL rr_data: grant %0d got %0h expected %0h", g, bus.mem_data_o, mk_data(exp_port, 0)); end
      bus.mem_ack_i = 1'b1;
      #1;
      checks++; if (bus.port_ack_o !== (2'b01 << exp_port)) begin errors++; $display("FAIL rr_ack: grant %0d got %0b expected %0b", g, bus.port_ack_o, 2'b01 << exp_port); end
      tick();
      bus.mem_ack_i = 1'b0;
    end
    bus.port_req_i = 2'b00;
    tick();
  endtask

  task automatic test_max_tx();
    bit ok;
    logic [RTW-1:0] rdata;
    rdata = {64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 64'h9999_AAAA_BBBB_CCCC};
    do_reset();
    bus.port_data_i[0] = mk_data(0, 3);
    bus.port_req_i     = 2'b01;
    for (int g = 0; g < 4; g++) begin
      bus.port_tid_i[0] = IW'(g);
      wait_req(ok);
      checks++; if (!ok || bus.mem_tid_o !== TW'(g)) begin errors++; $display("FAIL max_fill_tid: grant %0d got %0h expected %0h", g, bus.mem_tid_o, g); end
      bus.mem_ack_i = 1'b1;
      tick();
      bus.mem_ack_i = 1'b0;
    end
    checks++; if (dut.outstanding[0] !== 3'd4) begin errors++; $display("FAIL max_count: got %0d expected 4", dut.outstanding[0]); end
    bus.port_tid_i[0]  = 2'd2;
    bus.port_tid_i[1]  = 2'd0;
    bus.port_data_i[1] = mk_data(1, 7);
    bus.port_req_i     = 2'b11;
    wait_req(ok);
    checks++; if (!ok || bus.mem_tid_o !== 3'b100) begin errors++; $display("FAIL max_port1_tid: got %0h expected 4", bus.mem_tid_o); end
    bus.mem_ack_i = 1'b1;
    #1;
    checks++; if (bus.port_ack_o !== 2'b10) begin errors++; $display("FAIL max_port1_ack: got %0b expected 10", bus.port_ack_o); end
    tick();
    bus.mem_ack_i  = 1'b0;
    bus.port_req_i = 2'b01;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++; if (bus.mem_req_o !== 1'b0) begin errors++; $display("FAIL max_blocked: cycle %0d got mem_req_o %0b expected 0", c, bus.mem_req_o); end
    end
    bus.mem_rtrn_vld_i = 1'b1;
    bus.mem_rtrn_tid_i = 3'b010;
    bus.mem_rtrn_i     = rdata;
    tick();
    bus.mem_rtrn_vld_i = 1'b0;
    checks++; if (dut.outstanding[0] !== 3'd3) begin errors++; $display("FAIL max_after_rtrn_count: got %0d expected 3", dut.outstanding[0]); end
    checks++; if (bus.mem_req_o !== 1'b0) begin errors++; $display("FAIL max_same_cycle_grant: got %0b expected 0", bus.mem_req_o); end
    checks++; if (bus.port_rtrn_vld_o !== 2'b01 || bus.port_rtrn_tid_o !== 2'd2) begin errors++; $display("FAIL max_rtrn: got vld %0b tid %0d expected 01 2", bus.port_rtrn_vld_o, bus.port_rtrn_tid_o); end
    tick();
    checks++; if (bus.mem_req_o !== 1'b1 || bus.mem_tid_o !== 3'b010) begin errors++; $display("FAIL max_regrant: got req %0b tid %0h expected 1 2", bus.mem_req_o, bus.mem_tid_o); end
    bus.mem_ack_i = 1'b1;
    #1;
    checks++; if (bus.port_ack_o !== 2'b01) begin errors++; $display("FAIL max_regrant_ack: got %0b expected 01", bus.port_ack_o); end
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_return_route();
    bit ok;
    logic [RTW-1:0] rdata;
    rdata = {64'hDEAD_BEEF_0000_0001, 64'hFEED_FACE_0000_0002, 64'hCAFE_F00D_0000_0003};
    do_reset();
    bus.port_tid_i[1] = 2'd3;
    bus.port_req_i    = 2'b10;
    wait_req(ok);
    checks++; if (!ok || bus.mem_tid_o !== 3'b111) begin errors++; $display("FAIL route_grant_tid: got %0h expected 7", bus.mem_tid_o); end
    bus.mem_ack_i = 1'b1;
    tick();
    bus.mem_ack_i  = 1'b0;
    bus.port_req_i = 2'b00;
    bus.mem_rtrn_vld_i = 1'b1;
    bus.mem_rtrn_tid_i = 3'b111;
    bus.mem_rtrn_i     = rdata;
    #1;
    checks++; if (bus.port_rtrn_vld_o !== 2'b00) begin errors++; $display("FAIL route_latency: got %0b expected 00", bus.port_rtrn_vld_o); end
    tick();
    bus.mem_rtrn_vld_i = 1'b0;
    checks++; if (bus.port_rtrn_vld_o !== 2'b10) begin errors++; $display("FAIL route_vld: got %0b expected 10", bus.port_rtrn_vld_o); end
    checks++; if (bus.port_rtrn_tid_o !== 2'd3) begin errors++; $display("FAIL route_tid: got %0d expected 3", bus.port_rtrn_tid_o); end
    checks++; if (bus.port_rtrn_o !== rdata) begin errors++; $display("FAIL route_data: got %0h expected %0h", bus.port_rtrn_o, rdata); end
    checks++; if (dut.outstanding[1] !== 3'd0) begin errors++; $display("FAIL route_count: got %0d expected 0", dut.outstanding[1]); end
    tick();
    checks++; if (bus.port_rtrn_vld_o !== 2'b00) begin errors++; $display("FAIL route_vld_pulse: got %0b expected 00", bus.port_rtrn_vld_o); end
  endtask

  task automatic test_simultaneous();
    bit ok;
    do_reset();
    bus.port_req_i = 2'b01;
    for (int g = 0; g < 2; g++) begin
      bus.port_tid_i[0] = IW'(g);
      wait_req(ok);
      bus.mem_ack_i = 1'b1;
      tick();
      bus.mem_ack_i = 1'b0;
    end
    checks++; if (dut.outstanding[0] !== 3'd2) begin errors++; $display("FAIL simul_pre_count: got %0d expected 2", dut.outstanding[0]); end
    bus.port_tid_i[0] = 2'd2;
    wait_req(ok);
    bus.mem_ack_i      = 1'b1;
    bus.mem_rtrn_vld_i = 1'b1;
    bus.mem_rtrn_tid_i = 3'b000;
    #1;
    checks++; if (!ok || bus.port_ack_o !== 2'b01) begin errors++; $display("FAIL simul_ack: got %0b expected 01", bus.port_ack_o); end
    tick();
    clear_inputs();
    checks++; if (dut.outstanding[0] !== 3'd2) begin errors++; $display("FAIL simul_count: got %0d expected 2", dut.outstanding[0]); end
    checks++; if (bus.port_rtrn_vld_o !== 2'b01) begin errors++; $display("FAIL simul_rtrn_vld: got %0b expected 01", bus.port_rtrn_vld_o); end
    tick();
  endtask

  task automatic test_reset_busy();
    bit ok;
    do_reset();
    bus.port_req_i    = 2'b01;
    bus.port_tid_i[0] = 2'd0;
    wait_req(ok);
    bus.mem_ack_i = 1'b1;
    tick();
    bus.mem_ack_i     = 1'b0;
    bus.port_tid_i[0] = 2'd1;
    wait_req(ok);
    checks++; if (!ok || bus.mem_tid_o !== 3'b001) begin errors++; $display("FAIL rstbusy_pre: got req %0b tid %0h expected 1 1", bus.mem_req_o, bus.mem_tid_o); end
    #2;
    bus.mem_ack_i = 1'b1;
    rst = 1'b1;
    #1;
    checks++; if (bus.mem_req_o !== 1'b0) begin errors++; $display("FAIL rstbusy_mem_req: got %0b expected 0", bus.mem_req_o); end
    checks++; if (bus.port_ack_o !== 2'b00) begin errors++; $display("FAIL rstbusy_ack: got %0b expected 00", bus.port_ack_o); end
    checks++; if (dut.outstanding[0] !== 3'd0) begin errors++; $display("FAIL rstbusy_count: got %0d expected 0", dut.outstanding[0]); end
    tick();
    bus.mem_ack_i     = 1'b0;
    bus.port_req_i    = 2'b11;
    bus.port_tid_i[0] = 2'd2;
    bus.port_tid_i[1] = 2'd3;
    rst = 1'b0;
    wait_req(ok);
    checks++; if (!ok || bus.mem_tid_o !== 3'b010) begin errors++; $display("FAIL rstbusy_first_grant: got %0h expected 2", bus.mem_tid_o); end
    bus.mem_ack_i = 1'b1;
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_stall();
    bit ok;
    logic [RQW-1:0] exp_d;
    exp_d = mk_data(1, 5);
    do_reset();
    bus.port_data_i[1] = exp_d;
    bus.port_tid_i[1]  = 2'd1;
    bus.port_req_i     = 2'b10;
    wait_req(ok);
    checks++; if (!ok) begin errors++; $display("FAIL stall_req_timeout: got no mem_req_o expected 1"); end
    bus.port_data_i[1] = mk_data(1, 6);
    bus.port_tid_i[1]  = 2'd2;
    for (int c = 0; c < 10; c++) begin
      checks++; if (bus.mem_req_o !== 1'b1 || bus.mem_data_o !== exp_d) begin errors++; $display("FAIL stall_data: cycle %0d got req %0b data %0h expected 1 %0h", c, bus.mem_req_o, bus.mem_data_o, exp_d); end
      checks++; if (bus.mem_tid_o !== 3'b101 || bus.port_ack_o !== 2'b00) begin errors++; $display("FAIL stall_tid_ack: cycle %0d got tid %0h ack %0b expected 5 00", c, bus.mem_tid_o, bus.port_ack_o); end
      tick();
    end
    bus.mem_ack_i = 1'b1;
    #1;
    checks++; if (bus.port_ack_o !== 2'b10) begin errors++; $display("FAIL stall_release_ack: got %0b expected 10", bus.port_ack_o); end
    tick();
    clear_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_max_tx();
    test_return_route();
    test_simultaneous();
    test_reset_busy();
    test_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1);
  end

endmodule
